// File: rtl/rgbw_pwm_gen.sv
// rgbw_pwm_gen: four-channel PWM generator for the RGBW lamp.
// Duty words are double-buffered (pending -> active) and committed only at a
// period boundary or on the IDLE->RUN transition, so outputs never glitch
// mid-period. The counter advances on the clk_half tick enable.
// Optional feature: define PWM_PHASE_STAGGER_EN to offset channel i's compare
// point by i*CH_STAGGER ticks, spreading the rising edges across the period.
module rgbw_pwm_gen #(
    parameter int WIDTH      = 8,
    parameter int CH_STAGGER = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_half,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] duty0,
    input  logic [WIDTH-1:0] duty1,
    input  logic [WIDTH-1:0] duty2,
    input  logic [WIDTH-1:0] duty3,
    output logic             d0,
    output logic             d1,
    output logic             d2,
    output logic             d3,
    output logic             period_start,
    output logic             pending
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] active  [4];
    logic [WIDTH-1:0] pend    [4];
    logic [WIDTH-1:0] duty_in [4];
    logic [WIDTH-1:0] cmp_cnt [4];
    logic [3:0]       hit;
    logic [3:0]       dv;
    logic             wrap;
    logic             commit;

    assign d0 = dv[0];
    assign d1 = dv[1];
    assign d2 = dv[2];
    assign d3 = dv[3];

    // Gather the duty inputs and derive wrap / commit events.
    always_comb begin
        duty_in[0] = duty0;
        duty_in[1] = duty1;
        duty_in[2] = duty2;
        duty_in[3] = duty3;
        wrap   = (state == RUN) && en && clk_half && (cnt == CNT_MAX);
        commit = wrap || ((state == IDLE) && en);
    end

    // Per-channel compare value and next PWM level (full scale forces constant high).
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < 4; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
            cmp_cnt[i] = cnt + WIDTH'(i * unsigned'(CH_STAGGER));
`else
            cmp_cnt[i] = cnt;
`endif
            hit[i] = (active[i] == CNT_MAX) || (cmp_cnt[i] < active[i]);
        end
    end

    // State machine, counter, duty double-buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            pending      <= 1'b0;
            period_start <= 1'b0;
            dv           <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                active[i] <= '0;
                pend[i]   <= '0;
            end
        end else begin
            period_start <= wrap;

            // A load coinciding with a commit bypasses the pending stage.
            if (commit) begin
                pending <= 1'b0;
                for (int unsigned i = 0; i < 4; i++) begin
                    if (load) begin
                        pend[i]   <= duty_in[i];
                        active[i] <= duty_in[i];
                    end else if (pending) begin
                        active[i] <= pend[i];
                    end
                end
            end else if (load) begin
                pending <= 1'b1;
                for (int unsigned i = 0; i < 4; i++) begin
                    pend[i] <= duty_in[i];
                end
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    dv  <= '0;
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                        dv    <= '0;
                    end else begin
                        dv <= hit;
                        if (clk_half) begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    dv    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgbw_pwm_gen.sv
// Testbench for rgbw_pwm_gen: directed scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural model through a scoreboard queue.
module tb_rgbw_pwm_gen;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;
    localparam int STG  = 64;

    logic         clk = 1'b0;
    logic         reset, clk_half, en, load;
    logic [W-1:0] duty0, duty1, duty2, duty3;
    logic         d0, d1, d2, d3, period_start, pending;

    always #5 clk = ~clk;

    rgbw_pwm_gen #(.WIDTH(W), .CH_STAGGER(STG)) dut (
        .clk(clk), .reset(reset), .clk_half(clk_half), .en(en), .load(load),
        .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty3(duty3),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .period_start(period_start), .pending(pending)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] exp_q[$];

    // stimulus values for the next tick
    bit i_reset, i_half, i_en, i_load;
    int i_duty[4];

    // behavioural model state (value the DUT holds before the next edge)
    bit m_run;
    int m_cnt;
    int m_act[4];
    int m_pnd[4];
    bit m_pending;

    function automatic bit level(input int c, input int a, input int ch);
        int off;
`ifdef PWM_PHASE_STAGGER_EN
        off = ch * STG;
`else
        off = 0;
`endif
        if (a == MAXV) return 1'b1;
        return ((c + off) % (MAXV + 1)) < a;
    endfunction

    // One clock of stimulus: drive at negedge, predict the post-edge outputs.
    task automatic tick();
        logic [3:0] ed;
        bit ps, cm;
        @(negedge clk);
        reset    = i_reset;
        clk_half = i_half;
        en       = i_en;
        load     = i_load;
        duty0    = W'(i_duty[0]);
        duty1    = W'(i_duty[1]);
        duty2    = W'(i_duty[2]);
        duty3    = W'(i_duty[3]);
        if (i_reset) begin
            m_run = 0; m_cnt = 0; m_pending = 0;
            for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_pnd[i] = 0; end
            exp_q.push_back(6'b0);
        end else begin
            for (int i = 0; i < 4; i++)
                ed[i] = (m_run && i_en) ? level(m_cnt, m_act[i], i) : 1'b0;
            ps = m_run && i_en && i_half && (m_cnt == MAXV);
            cm = ps || (!m_run && i_en);
            if (cm) begin
                for (int i = 0; i < 4; i++) begin
                    if (i_load) begin m_act[i] = i_duty[i]; m_pnd[i] = i_duty[i]; end
                    else if (m_pending) m_act[i] = m_pnd[i];
                end
                m_pending = 0;
            end else if (i_load) begin
                for (int i = 0; i < 4; i++) m_pnd[i] = i_duty[i];
                m_pending = 1;
            end
            if (m_run && i_en) begin
                if (i_half) m_cnt = (m_cnt + 1) % (MAXV + 1);
            end else begin
                m_cnt = 0;
            end
            m_run = i_en;
            exp_q.push_back({ed, ps, m_pending});
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Advance until the model counter reaches v (bounded).
    task automatic wait_cnt(input int v);
        for (int k = 0; k < 3000 && m_cnt != v; k++) tick();
    endtask

    // Monitor: outputs are presented every clock; compare just after the edge.
    initial begin
        logic [5:0] e, a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {d3, d2, d1, d0, period_start, pending};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got {d3..d0,ps,pend}=%b expected %b", $time, a, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; clk_half = 1'b0; en = 1'b0; load = 1'b0;
        duty0 = '0; duty1 = '0; duty2 = '0; duty3 = '0;
        i_reset = 1; i_half = 0; i_en = 0; i_load = 0;
        for (int i = 0; i < 4; i++) i_duty[i] = 0;
        run(2);

        // 1: basic duties, full-rate ticks
        i_reset = 0; i_en = 1; i_half = 1;
        run(5);
        i_load = 1; i_duty[0] = 64; i_duty[1] = 0; i_duty[2] = 255; i_duty[3] = 128;
        tick();
        i_load = 0;
        run(600);

        // 2: load mid-period is held pending until the wrap
        wait_cnt(100);
        i_load = 1; i_duty[0] = 200; tick(); i_load = 0;
        run(400);

        // 3: last load before the commit wins
        wait_cnt(20);
        i_load = 1; i_duty[0] = 10; tick(); i_load = 0;
        wait_cnt(80);
        i_load = 1; i_duty[0] = 20; tick(); i_load = 0;
        run(300);

        // 4: load coinciding with a wrap event
        wait_cnt(255);
        i_load = 1; i_duty[0] = 30; tick(); i_load = 0;
        run(300);

        // 5: drop enable mid-period, then resume
        wait_cnt(50);
        i_en = 0; run(5);
        i_en = 1; run(300);

        // 6: half-rate ticks, then reset mid-period
        for (int k = 0; k < 1100; k++) begin i_half = (k % 2 == 0); tick(); end
        i_reset = 1; tick(); i_reset = 0;
        i_en = 0; run(3);

        // equal duties on all channels (shows the stagger when enabled)
        i_en = 1; i_half = 1; i_load = 1;
        for (int i = 0; i < 4; i++) i_duty[i] = 64;
        tick(); i_load = 0;
        run(600);

        // clk_half stuck low: everything freezes
        i_half = 0; run(20); i_half = 1;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            i_reset = ($urandom_range(0, 599) == 0);
            i_en    = ($urandom_range(0, 49) != 0);
            i_half  = ($urandom_range(0, 3) != 0);
            i_load  = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: i_duty[i] = 0;
                    1: i_duty[i] = MAXV;
                    default: i_duty[i] = int'($urandom_range(0, MAXV));
                endcase
            end
            tick();
        end
        i_reset = 0; i_load = 0;

        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d leftover expectations required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
